// File: rtl/mdu_pkg.sv
// RV32M multiply/divide unit shared definitions.
// funct3 opcode constants and divider FSM state type.
package mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'd0;
  localparam logic [2:0] MDU_MULH   = 3'd1;
  localparam logic [2:0] MDU_MULHSU = 3'd2;
  localparam logic [2:0] MDU_MULHU  = 3'd3;
  localparam logic [2:0] MDU_DIV    = 3'd4;
  localparam logic [2:0] MDU_DIVU   = 3'd5;
  localparam logic [2:0] MDU_REM    = 3'd6;
  localparam logic [2:0] MDU_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

endpackage

// File: rtl/mdu_divider.sv
// Iterative restoring divider, one quotient bit per cycle.
// Ports: clk/rst_n/en/flush, start+op/a/b/pos in, state/done/res/rob_pos out, ack in.
module mdu_divider
  import mdu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ROB_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 flush,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [XLEN-1:0]      a,
  input  logic [XLEN-1:0]      b,
  input  logic [ROB_IDX_W-1:0] pos,
  input  logic                 ack,
  output div_state_t           state,
  output logic                 done,
  output logic [XLEN-1:0]      res,
  output logic [ROB_IDX_W-1:0] rob_pos
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t state_d;

  logic [XLEN-1:0] q, r, d;
  logic [CW-1:0]   cnt;
  logic            neg_q, neg_r, rem_sel;
  logic            sgn, a_neg, b_neg, ovf, b_zero;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   rem_sh, diff;

  assign sgn    = ~op[0];
  assign a_neg  = sgn & a[XLEN-1];
  assign b_neg  = sgn & b[XLEN-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;
  assign b_zero = (b == '0);
  assign ovf    = sgn && (a == MIN_NEG) && (&b);

  // MSB of diff is the borrow: set means the trial subtract failed.
  assign rem_sh = {r, q[XLEN-1]};
  assign diff   = rem_sh - {1'b0, d};

  always_comb begin
    state_d = state;
    if (flush) begin
      state_d = IDLE;
    end else if (en) begin
      unique case (state)
        IDLE: if (start) state_d = (b_zero || ovf) ? DONE : CALC;
        CALC: if (cnt == CW'(XLEN-1)) state_d = DONE;
        DONE: if (ack) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      q       <= '0;
      r       <= '0;
      d       <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      rem_sel <= 1'b0;
      rob_pos <= '0;
    end else if (!flush && en) begin
      if (state == IDLE && start) begin
        cnt     <= '0;
        rem_sel <= op[1];
        rob_pos <= pos;
        d       <= b_mag;
        if (b_zero) begin
          q     <= '1;
          r     <= a;
          neg_q <= 1'b0;
          neg_r <= 1'b0;
        end else if (ovf) begin
          q     <= a;
          r     <= '0;
          neg_q <= 1'b0;
          neg_r <= 1'b0;
        end else begin
          q     <= a_mag;
          r     <= '0;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
        end
      end else if (state == CALC) begin
        cnt <= cnt + 1'b1;
        if (!diff[XLEN]) begin
          r <= diff[XLEN-1:0];
          q <= {q[XLEN-2:0], 1'b1};
        end else begin
          r <= rem_sh[XLEN-1:0];
          q <= {q[XLEN-2:0], 1'b0};
        end
      end
    end
  end

  assign done = (state == DONE);
  assign res  = rem_sel ? (neg_r ? -r : r)
                        : (neg_q ? -q : q);

endmodule

// File: rtl/ex_mdu.sv
// RV32M execute unit: pipelined multiplier plus iterative divider on one result port.
// Ports: clk/rst/rdy/flush, RS issue handshake + operands, result broadcast, busy.
module ex_mdu
  import mdu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ROB_IDX_W  = 4,
  parameter int MUL_STAGES = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rdy_in,
  input  logic                 flush_in,
  input  logic                 issue_valid_in,
  output logic                 issue_ready_out,
  input  logic [2:0]           op_in,
  input  logic [XLEN-1:0]      rs1_in,
  input  logic [XLEN-1:0]      rs2_in,
  input  logic [ROB_IDX_W-1:0] rob_pos_in,
  output logic                 res_valid_out,
  output logic [XLEN-1:0]      res_out,
  output logic [ROB_IDX_W-1:0] rob_pos_out,
  output logic                 busy_out
);

  localparam int L = MUL_STAGES - 1;

  div_state_t div_state;
  logic            div_done, div_ack, div_start, mul_fire, accept;
  logic [XLEN-1:0] div_res;
  logic [ROB_IDX_W-1:0] div_pos;

  logic [MUL_STAGES-1:0] mv;
  logic [ROB_IDX_W-1:0]  mpos  [MUL_STAGES];
  logic [1:0]            mop   [MUL_STAGES];
  logic [2*XLEN-1:0]     mprod [MUL_STAGES];

  logic              a_sgn, b_sgn;
  logic [2*XLEN-1:0] a_ext, b_ext, prod;
  logic [XLEN-1:0]   mul_res;

  // A finished divide holds new muls off so it gets the port soon.
  assign issue_ready_out = rdy_in && !flush_in &&
    (op_in[2] ? (div_state == IDLE) : (div_state != DONE));

  assign accept    = issue_valid_in && issue_ready_out;
  assign mul_fire  = accept && !op_in[2];
  assign div_start = accept && op_in[2];

  // Low 2*XLEN bits of the extended product are exact for every sign mix.
  assign a_sgn = (op_in == MDU_MULH) || (op_in == MDU_MULHSU);
  assign b_sgn = (op_in == MDU_MULH);
  assign a_ext = {{XLEN{a_sgn & rs1_in[XLEN-1]}}, rs1_in};
  assign b_ext = {{XLEN{b_sgn & rs2_in[XLEN-1]}}, rs2_in};
  assign prod  = a_ext * b_ext;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      mv <= '0;
    end else if (flush_in) begin
      mv <= '0;
    end else if (rdy_in) begin
      mv[0] <= mul_fire;
      for (int i = 1; i < MUL_STAGES; i++) mv[i] <= mv[i-1];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in && !flush_in) begin
      mpos[0]  <= rob_pos_in;
      mop[0]   <= op_in[1:0];
      mprod[0] <= prod;
      for (int i = 1; i < MUL_STAGES; i++) begin
        mpos[i]  <= mpos[i-1];
        mop[i]   <= mop[i-1];
        mprod[i] <= mprod[i-1];
      end
    end
  end

  assign mul_res = (mop[L] == 2'b00) ? mprod[L][XLEN-1:0]
                                     : mprod[L][2*XLEN-1:XLEN];

  assign div_ack = rdy_in && !flush_in && !mv[L];

  mdu_divider #(
    .XLEN      (XLEN),
    .ROB_IDX_W (ROB_IDX_W)
  ) u_div (
    .clk     (clk_in),
    .rst_n   (rst_n_in),
    .en      (rdy_in),
    .flush   (flush_in),
    .start   (div_start),
    .op      (op_in[1:0]),
    .a       (rs1_in),
    .b       (rs2_in),
    .pos     (rob_pos_in),
    .ack     (div_ack),
    .state   (div_state),
    .done    (div_done),
    .res     (div_res),
    .rob_pos (div_pos)
  );

  always_comb begin
    res_valid_out = rdy_in && !flush_in && (mv[L] || div_done);
    res_out       = '0;
    rob_pos_out   = '0;
    if (mv[L]) begin
      res_out     = mul_res;
      rob_pos_out = mpos[L];
    end else if (div_done) begin
      res_out     = div_res;
      rob_pos_out = div_pos;
    end
  end

  assign busy_out = (|mv) || (div_state != IDLE);

endmodule
